// File: rtl/mor1kx_true_dpram_be_sclk.sv
// mor1kx_true_dpram_be_sclk: single-clock true dual-port RAM with byte enables,
// selectable read-during-write, optional output register and post-reset clear.
module mor1kx_true_dpram_be_sclk #(
  parameter int    ADDR_WIDTH     = 8,
  parameter int    DATA_WIDTH     = 32,
  parameter int    BE_WIDTH       = DATA_WIDTH / 8,
  parameter string RW_MODE        = "WRITE_FIRST",
  parameter bit    OUT_REG        = 1'b0,
  parameter bit    CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  init_busy_o,
  input  logic                  en_a,
  input  logic                  we_a,
  input  logic [BE_WIDTH-1:0]   be_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] din_a,
  output logic [DATA_WIDTH-1:0] dout_a,
  input  logic                  en_b,
  input  logic                  we_b,
  input  logic [BE_WIDTH-1:0]   be_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] din_b,
  output logic [DATA_WIDTH-1:0] dout_b,
  output logic                  collision_o
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam bit WF = RW_MODE == "WRITE_FIRST";
  typedef enum logic {INIT, RUN} state_t;
  state_t                  state;
  logic [ADDR_WIDTH-1:0]   cnt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic                    run, acc_a, acc_b, same, col, v_a, v_b, c1;
  logic [BE_WIDTH-1:0]     wa, wb;
  logic [DATA_WIDTH-1:0]   old_a, old_b, mg_a, mg_b, rd_a, rd_b, p_a, p_b;
  always_comb begin
    run   = rst_n && state == RUN;
    acc_a = run && en_a;
    acc_b = run && en_b;
    wa    = acc_a && we_a ? be_a : '0;
    wb    = acc_b && we_b ? be_b : '0;
    same  = addr_a == addr_b;
    col   = acc_a && acc_b && same && (|wa || |wb);
    old_a = mem[addr_a];
    old_b = mem[addr_b];
    mg_a  = old_a;
    mg_b  = old_b;
    for (int i = 0; i < BE_WIDTH; i++) begin
      mg_a[8*i+:8] = wa[i] ? din_a[8*i+:8] : old_a[8*i+:8];
      mg_b[8*i+:8] = wb[i] ? din_b[8*i+:8] : old_b[8*i+:8];
    end
    rd_a = WF ? mg_a : old_a;
    rd_b = WF ? mg_b : old_b;
  end
  // on a shared address port A owns every byte it enables
  always_ff @(posedge clk) begin
    if (state == INIT)
      mem[cnt] <= '0;
    else
      for (int i = 0; i < BE_WIDTH; i++) begin
        if (wb[i] && !(same && wa[i])) mem[addr_b][8*i+:8] <= din_b[8*i+:8];
        if (wa[i]) mem[addr_a][8*i+:8] <= din_a[8*i+:8];
      end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= CLEAR_ON_RESET ? INIT : RUN;
      cnt         <= '0;
      init_busy_o <= CLEAR_ON_RESET;
    end else if (state == INIT) begin
      cnt <= cnt + 1'b1;
      if (cnt == '1) begin
        state       <= RUN;
        init_busy_o <= 1'b0;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_a         <= '0;
      p_b         <= '0;
      v_a         <= 1'b0;
      v_b         <= 1'b0;
      c1          <= 1'b0;
      dout_a      <= '0;
      dout_b      <= '0;
      collision_o <= 1'b0;
    end else begin
      if (acc_a) p_a <= rd_a;
      if (acc_b) p_b <= rd_b;
      v_a <= acc_a;
      v_b <= acc_b;
      c1  <= col;
      if (OUT_REG ? v_a : acc_a) dout_a <= OUT_REG ? p_a : rd_a;
      if (OUT_REG ? v_b : acc_b) dout_b <= OUT_REG ? p_b : rd_b;
      collision_o <= OUT_REG ? c1 : col;
    end
  end
endmodule

// File: tb/tb_mor1kx_true_dpram_be_sclk.sv
// tb_mor1kx_true_dpram_be_sclk: two configurations (write-first/latency 1 and
// read-first/latency 2) driven in lockstep against a word-level array model.
module tb_mor1kx_true_dpram_be_sclk;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        en_a, we_a, en_b, we_b;
  logic [3:0]  be_a, be_b, addr_a, addr_b;
  logic [31:0] din_a, din_b, dout_a0, dout_b0, dout_a1, dout_b1;
  logic        busy0, busy1, col0, col1;
  int          total = 0, bad = 0;
  always #5 clk = ~clk;
  mor1kx_true_dpram_be_sclk #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .RW_MODE("WRITE_FIRST"),
    .OUT_REG(1'b0), .CLEAR_ON_RESET(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n), .init_busy_o(busy0),
    .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a0),
    .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .din_b(din_b), .dout_b(dout_b0),
    .collision_o(col0));
  mor1kx_true_dpram_be_sclk #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .RW_MODE("READ_FIRST"),
    .OUT_REG(1'b1), .CLEAR_ON_RESET(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .init_busy_o(busy1),
    .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a1),
    .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .din_b(din_b), .dout_b(dout_b1),
    .collision_o(col1));
  typedef struct {
    logic en_a, we_a; logic [3:0] be_a, addr_a; logic [31:0] din_a;
    logic en_b, we_b; logic [3:0] be_b, addr_b; logic [31:0] din_b;
    logic [31:0] xa, xb; logic xc;
  } vec_t;
  vec_t tbl[10];
  logic [31:0] m [16];
  logic [31:0] e0a, e0b, e1a, e1b, pa, pb;
  logic        e0c, e1c, pc, pva, pvb;
  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i+:8] = be[i] ? d[8*i+:8] : o[8*i+:8];
    return r;
  endfunction
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", n, act, exp);
    end
  endtask
  task automatic model_reset();
    {e0a, e0b, e1a, e1b, pa, pb} = '0;
    {e0c, e1c, pc, pva, pvb} = '0;
  endtask
  // one accepted cycle: writer sees its merged word (write-first) or the old word
  // (read-first), a cross-port reader always sees the old word, A wins byte ties
  task automatic model_step();
    logic [3:0]  wa, wb;
    logic [31:0] oa, ob;
    logic        c;
    wa = (en_a && we_a) ? be_a : 4'h0;
    wb = (en_b && we_b) ? be_b : 4'h0;
    oa = m[addr_a];
    ob = m[addr_b];
    c  = en_a && en_b && addr_a == addr_b && (wa != 4'h0 || wb != 4'h0);
    if (en_a) e0a = merge(oa, din_a, wa);
    if (en_b) e0b = merge(ob, din_b, wb);
    e0c = c;
    if (pva) e1a = pa;
    if (pvb) e1b = pb;
    e1c = pc;
    if (en_a) pa = oa;
    if (en_b) pb = ob;
    pva = en_a;
    pvb = en_b;
    pc  = c;
    m[addr_b] = merge(m[addr_b], din_b, wb);
    m[addr_a] = merge(m[addr_a], din_a, wa);
  endtask
  task automatic check_all();
    chk("wf_dout_a", dout_a0, e0a);
    chk("wf_dout_b", dout_b0, e0b);
    chk("wf_collision", {31'b0, col0}, {31'b0, e0c});
    chk("rf_reg_dout_a", dout_a1, e1a);
    chk("rf_reg_dout_b", dout_b1, e1b);
    chk("rf_reg_collision", {31'b0, col1}, {31'b0, e1c});
  endtask
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask
  task automatic idle();
    {en_a, we_a, en_b, we_b} = '0;
    {be_a, be_b, addr_a, addr_b} = '0;
    {din_a, din_b} = '0;
  endtask
  task automatic drive(input vec_t v);
    en_a = v.en_a; we_a = v.we_a; be_a = v.be_a; addr_a = v.addr_a; din_a = v.din_a;
    en_b = v.en_b; we_b = v.we_b; be_b = v.be_b; addr_b = v.addr_b; din_b = v.din_b;
  endtask
  task automatic check_reset_outputs(input string n);
    chk({n, "_busy"}, {30'b0, busy0, busy1}, 32'h3);
    chk({n, "_dout"}, dout_a0 | dout_b0 | dout_a1 | dout_b1, 32'h0);
    chk({n, "_col"}, {30'b0, col0, col1}, 32'h0);
  endtask
  // release reset with hostile port activity; the clear must ignore it
  task automatic init_clear();
    int n;
    en_a = 1'b1; we_a = 1'b1; be_a = 4'hF; din_a = 32'hFFFF_FFFF; addr_a = 4'd8;
    en_b = 1'b1; we_b = 1'b1; be_b = 4'hF; din_b = 32'h5A5A_5A5A; addr_b = 4'd9;
    #2 rst_n = 1'b1;
    n = 0;
    while (busy0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      addr_a = 4'($urandom);
      addr_b = 4'($urandom);
      chk("init_dout_held", dout_a0 | dout_b0 | dout_a1 | dout_b1 | {30'b0, col0, col1}, 32'h0);
    end
    chk("init_cycles", 32'(n), 32'd16);
    chk("init_busy_rf", {31'b0, busy1}, 32'h0);
    idle();
    for (int i = 0; i < 16; i++) m[i] = 32'h0;
    for (int i = 0; i < 16; i++) begin
      en_a = 1'b1; addr_a = 4'(i);
      en_b = 1'b1; addr_b = 4'(15 - i);
      tick();
      chk("clear_rd_a", dout_a0, 32'h0);
      chk("clear_rd_b", dout_b0, 32'h0);
    end
    idle();
    repeat (2) tick();
  endtask
  initial begin
    tbl[0] = '{1'b1, 1'b1, 4'hF, 4'd5, 32'hAABBCCDD, 1'b0, 1'b0, 4'h0, 4'd0, 32'h0, 32'hAABBCCDD, 32'h0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 4'h5, 4'd5, 32'h11223344, 1'b0, 1'b0, 4'h0, 4'd0, 32'h0, 32'hAA22CC44, 32'h0, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 4'h0, 4'd5, 32'h0, 1'b0, 1'b0, 4'h0, 4'd0, 32'h0, 32'hAA22CC44, 32'h0, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 4'hC, 4'd7, 32'hFFFFFFFF, 1'b0, 1'b0, 4'h0, 4'd0, 32'h0, 32'hFFFF0000, 32'h0, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 4'h1, 4'd3, 32'h000000AA, 1'b1, 1'b1, 4'h3, 4'd3, 32'h0000BBBB, 32'h000000AA, 32'h0000BBBB, 1'b1};
    tbl[5] = '{1'b1, 1'b0, 4'h0, 4'd3, 32'h0, 1'b1, 1'b0, 4'h0, 4'd3, 32'h0, 32'h0000BBAA, 32'h0000BBAA, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 4'hF, 4'd9, 32'h12345678, 1'b1, 1'b0, 4'h0, 4'd9, 32'h0, 32'h12345678, 32'h0, 1'b1};
    tbl[7] = '{1'b0, 1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 1'b0, 4'h0, 4'd9, 32'h0, 32'h12345678, 32'h12345678, 1'b0};
    tbl[8] = '{1'b1, 1'b1, 4'h0, 4'd7, 32'hDEADBEEF, 1'b0, 1'b0, 4'h0, 4'd0, 32'h0, 32'hFFFF0000, 32'h12345678, 1'b0};
    tbl[9] = '{1'b1, 1'b0, 4'h0, 4'd7, 32'h0, 1'b1, 1'b0, 4'h0, 4'd5, 32'h0, 32'hFFFF0000, 32'hAA22CC44, 1'b0};
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    init_clear();
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i]);
      tick();
      chk("tbl_dout_a", dout_a0, tbl[i].xa);
      chk("tbl_dout_b", dout_b0, tbl[i].xb);
      chk("tbl_collision", {31'b0, col0}, {31'b0, tbl[i].xc});
    end
    for (int i = 0; i < 400; i++) begin
      en_a = ($urandom % 4) != 0; we_a = 1'($urandom); be_a = 4'($urandom_range(1, 15));
      addr_a = 4'($urandom); din_a = $urandom;
      en_b = ($urandom % 4) != 0; we_b = 1'($urandom); be_b = 4'($urandom_range(1, 15));
      addr_b = ($urandom % 2) != 0 ? addr_a : 4'($urandom); din_b = $urandom;
      tick();
    end
    idle();
    repeat (2) tick();
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    model_reset();
    en_a = 1'b1; we_a = 1'b1; be_a = 4'hF; din_a = 32'hCAFE_F00D; addr_a = 4'd2;
    #2 rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("mid_init_reset");
    init_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
